// File: rtl/rx_tsoip_parser_pkg.sv
// Shared definitions for the TS-over-IP receive parser.
// Header offsets, field constants and the parser state encoding.
package rx_tsoip_parser_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        DISCARD
    } ParserState;

    localparam logic [7:0] OFF_MAC    = 8'd0;
    localparam logic [7:0] OFF_ETYPE  = 8'd12;
    localparam logic [7:0] OFF_VIHL   = 8'd14;
    localparam logic [7:0] OFF_PROTO  = 8'd23;
    localparam logic [7:0] OFF_IPDST  = 8'd30;
    localparam logic [7:0] OFF_UDPDST = 8'd36;
    localparam logic [7:0] OFF_UDPLEN = 8'd38;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  VIHL_IPV4      = 8'h45;
    localparam logic [47:0] BCAST_MAC      = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/rx_tsoip_parser_if.sv
// Byte stream bundle feeding the parser and its header comparator.
interface rx_tsoip_parser_if;

    logic       valid;
    logic       sync;
    logic       frameEnd;
    logic [7:0] data;

    modport master (
        output valid,
        output sync,
        output frameEnd,
        output data
    );

    modport slave (
        input valid,
        input sync,
        input frameEnd,
        input data
    );

endinterface

// File: rtl/rx_header_check.sv
// Combinational per-offset header field comparator.
// A sync byte is always judged as offset 0 of a fresh frame.
module rx_header_check
    import rx_tsoip_parser_pkg::*;
(
    rx_tsoip_parser_if.slave bus,
    input  logic [7:0]  hdrOff,
    input  logic [47:0] macLocal,
    input  logic [31:0] ipLocal,
    input  logic [7:0]  protocol,
    input  logic [15:0] portDest,
    input  logic [15:0] udpLen,
    input  logic        lenValid,
    input  logic        localOk,
    input  logic        bcastOk,
    output logic        localHit,
    output logic        bcastHit,
    output logic        mismatch
);

    logic [7:0] off;
    logic [2:0] macIdx;
    logic [1:0] ipIdx;
    logic       prevLocal;
    logic       prevBcast;
    logic       bad;

    always_comb begin
        off       = bus.sync ? OFF_MAC : hdrOff;
        prevLocal = bus.sync | localOk;
        prevBcast = bus.sync | bcastOk;
        localHit  = prevLocal;
        bcastHit  = prevBcast;
        macIdx    = 3'd0;
        ipIdx     = 2'd0;
        bad       = 1'b0;
        unique case (1'b1)
            (off < OFF_MAC + 8'd6): begin
                // local and broadcast matches are tracked separately
                macIdx   = 3'(off - OFF_MAC);
                localHit = prevLocal &&
                    (bus.data == macLocal[{3'd5 - macIdx, 3'b000} +: 8]);
                bcastHit = prevBcast && (bus.data == BCAST_MAC[7:0]);
                bad      = !(localHit || bcastHit);
            end
            (off == OFF_ETYPE):
                bad = bus.data != ETHERTYPE_IPV4[15:8];
            (off == OFF_ETYPE + 8'd1):
                bad = bus.data != ETHERTYPE_IPV4[7:0];
            (off == OFF_VIHL):
                bad = bus.data != VIHL_IPV4;
            (off == OFF_PROTO):
                bad = bus.data != protocol;
            (off >= OFF_IPDST && off < OFF_IPDST + 8'd4): begin
                ipIdx = 2'(off - OFF_IPDST);
                bad   = bus.data != ipLocal[{~ipIdx, 3'b000} +: 8];
            end
            (off == OFF_UDPDST):
                bad = bus.data != portDest[15:8];
            (off == OFF_UDPDST + 8'd1):
                bad = bus.data != portDest[7:0];
            (off == OFF_UDPLEN):
                bad = !lenValid || bus.data != udpLen[15:8];
            (off == OFF_UDPLEN + 8'd1):
                bad = !lenValid || bus.data != udpLen[7:0];
            default: ;
        endcase
        mismatch = bad && bus.valid;
    end

endmodule

// File: rtl/rx_tsoip_parser.sv
// Strips Ethernet/IPv4/UDP headers and forwards MPEG-TS payload bytes.
// Output stream is registered: one cycle from input byte to o_Data.
module rx_tsoip_parser
    import rx_tsoip_parser_pkg::*;
#(
    parameter int P_HDR_LEN = 42
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Valid,
    input  logic        i_Sync,
    input  logic        i_End,
    input  logic [7:0]  i_Data,
    input  logic [47:0] i_MacLocal,
    input  logic [31:0] i_IpLocal,
    input  logic [7:0]  i_Protocol,
    input  logic [15:0] i_PortDest,
    input  logic [7:0]  i_PacketLength,
    input  logic [2:0]  i_NumberPacket,
    output logic [7:0]  o_Data,
    output logic        o_Valid,
    output logic        o_Sync,
    output logic        o_End,
    output logic        o_Drop,
    output logic [15:0] o_FrameCnt,
    output logic [15:0] o_DropCnt
);

    localparam logic [7:0] LAST_HDR = 8'(P_HDR_LEN - 1);

    rx_tsoip_parser_if inBus ();

    assign inBus.valid    = i_Valid;
    assign inBus.sync     = i_Sync;
    assign inBus.frameEnd = i_End;
    assign inBus.data     = i_Data;

    ParserState  state, stateNext;
    logic [7:0]  hdrOff, hdrOffNext;
    logic [7:0]  tsCnt, tsCntNext;
    logic [15:0] payCnt, payCntNext;
    logic [15:0] total, udpLen;
    logic        localOk, bcastOk, localOkNext, bcastOkNext;
    logic        localHit, bcastHit, mismatch;
    logic [7:0]  dataNext;
    logic        validNext, syncNext, endNext, dropNext, frameDone;

    assign total  = 16'(i_NumberPacket) * 16'(i_PacketLength);
    assign udpLen = total + 16'd8;

    rx_header_check u_hdrCheck (
        .bus      (inBus.slave),
        .hdrOff   (hdrOff),
        .macLocal (i_MacLocal),
        .ipLocal  (i_IpLocal),
        .protocol (i_Protocol),
        .portDest (i_PortDest),
        .udpLen   (udpLen),
        .lenValid (i_NumberPacket != 3'd0),
        .localOk  (localOk),
        .bcastOk  (bcastOk),
        .localHit (localHit),
        .bcastHit (bcastHit),
        .mismatch (mismatch)
    );

    always_comb begin
        stateNext   = state;
        hdrOffNext  = hdrOff;
        payCntNext  = payCnt;
        tsCntNext   = tsCnt;
        localOkNext = localOk;
        bcastOkNext = bcastOk;
        dataNext    = o_Data;
        validNext   = 1'b0;
        syncNext    = 1'b0;
        endNext     = 1'b0;
        dropNext    = 1'b0;
        frameDone   = 1'b0;
        if (inBus.valid) begin
            if (inBus.sync) begin
                hdrOffNext  = 8'd1;
                localOkNext = localHit;
                bcastOkNext = bcastHit;
                if (inBus.frameEnd) begin
                    dropNext  = 1'b1;
                    stateNext = IDLE;
                end else begin
                    dropNext  = mismatch || state == HEADER ||
                                state == PAYLOAD;
                    stateNext = mismatch ? DISCARD : HEADER;
                end
            end else begin
                unique case (state)
                    HEADER: begin
                        hdrOffNext  = hdrOff + 8'd1;
                        localOkNext = localHit;
                        bcastOkNext = bcastHit;
                        if (mismatch || inBus.frameEnd) begin
                            dropNext  = 1'b1;
                            stateNext = inBus.frameEnd ? IDLE : DISCARD;
                        end else if (hdrOff == LAST_HDR) begin
                            stateNext  = PAYLOAD;
                            payCntNext = '0;
                            tsCntNext  = '0;
                        end
                    end
                    PAYLOAD: begin
                        dataNext   = inBus.data;
                        validNext  = 1'b1;
                        syncNext   = tsCnt == 8'd0;
                        payCntNext = payCnt + 16'd1;
                        tsCntNext  = (tsCnt == i_PacketLength - 8'd1) ?
                                     8'd0 : tsCnt + 8'd1;
                        if (payCnt == total - 16'd1) begin
                            endNext   = 1'b1;
                            frameDone = 1'b1;
                            stateNext = inBus.frameEnd ? IDLE : DISCARD;
                        end else if (inBus.frameEnd) begin
                            endNext   = 1'b1;
                            dropNext  = 1'b1;
                            stateNext = IDLE;
                        end
                    end
                    DISCARD: begin
                        if (inBus.frameEnd) stateNext = IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state      <= IDLE;
            hdrOff     <= '0;
            payCnt     <= '0;
            tsCnt      <= '0;
            localOk    <= 1'b0;
            bcastOk    <= 1'b0;
            o_Data     <= '0;
            o_Valid    <= 1'b0;
            o_Sync     <= 1'b0;
            o_End      <= 1'b0;
            o_Drop     <= 1'b0;
            o_FrameCnt <= '0;
            o_DropCnt  <= '0;
        end else begin
            state      <= stateNext;
            hdrOff     <= hdrOffNext;
            payCnt     <= payCntNext;
            tsCnt      <= tsCntNext;
            localOk    <= localOkNext;
            bcastOk    <= bcastOkNext;
            o_Data     <= dataNext;
            o_Valid    <= validNext;
            o_Sync     <= syncNext;
            o_End      <= endNext;
            o_Drop     <= dropNext;
            o_FrameCnt <= o_FrameCnt + 16'(frameDone);
            o_DropCnt  <= o_DropCnt + 16'(dropNext);
        end
    end

endmodule
